// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and divisor clamp helper for the programmable clock divider
package clkdiv_pkg;

  localparam int CLKDIV_MIN_DIV = 2;
  localparam int CLKDIV_DEF_W   = 8;
  localparam int CLKDIV_DEF_DIV = 20;

  // Written divisors below the minimum would give a period with no low phase.
  function automatic logic [31:0] clkdiv_clamp(input logic [31:0] v);
    return (v < 32'(CLKDIV_MIN_DIV)) ? 32'(CLKDIV_MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clkdiv_cfg_reg.sv
// rtl/clkdiv_cfg_reg.sv - pending/current divisor registers with apply-on-boundary handoff
module clkdiv_cfg_reg
  import clkdiv_pkg::*;
#(
  parameter int W           = CLKDIV_DEF_W,
  parameter int DEFAULT_DIV = CLKDIV_DEF_DIV
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         div_wr,
  input  logic [W-1:0] div_in,
  input  logic         apply,
  output logic [W-1:0] div_cur,
  output logic         div_pend
);

  logic [W-1:0] wr_val;
  logic [W-1:0] pend_val_q, pend_val_d;
  logic [W-1:0] cur_q, cur_d;
  logic         pend_q, pend_d;

  assign wr_val = W'(clkdiv_clamp(32'(div_in)));

  // A write landing on the apply edge wins over any older pending value.
  always_comb begin
    pend_val_d = pend_val_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    if (apply) begin
      if (div_wr) begin
        cur_d = wr_val;
      end else if (pend_q) begin
        cur_d = pend_val_q;
      end
      pend_d = 1'b0;
    end else if (div_wr) begin
      pend_val_d = wr_val;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q <= W'(DEFAULT_DIV);
      cur_q      <= W'(DEFAULT_DIV);
      pend_q     <= 1'b0;
    end else begin
      pend_val_q <= pend_val_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
    end
  end

  assign div_cur  = cur_q;
  assign div_pend = pend_q;

endmodule

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable integer clock divider with tick, gating and phase sync
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int W           = CLKDIV_DEF_W,
  parameter int DEFAULT_DIV = CLKDIV_DEF_DIV
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         en,
  input  logic         div_wr,
  input  logic [W-1:0] div_in,
  input  logic         sync,
  output logic         clk_out,
  output logic         tick,
  output logic         active,
  output logic         div_pend,
  output logic [W-1:0] div_cur
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         act_q, act_d;
  logic         last;
  logic         apply;
  logic [W:0]   high_len;
  logic [W:0]   cnt_inc;

  assign last     = act_q && (cnt_q == (div_cur - {{(W-1){1'b0}}, 1'b1}));
  assign apply    = en && (sync || !act_q || last);
  assign high_len = ({1'b0, div_cur} + {{W{1'b0}}, 1'b1}) >> 1;
  assign cnt_inc  = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};

  clkdiv_cfg_reg #(
    .W           (W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_cfg (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .apply    (apply),
    .div_cur  (div_cur),
    .div_pend (div_pend)
  );

  // Start, boundary-with-en and sync all begin a fresh period; stopping only happens at the last count.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    act_d  = act_q;
    if (apply) begin
      cnt_d  = '0;
      clk_d  = 1'b1;
      tick_d = 1'b1;
      act_d  = 1'b1;
    end else if (last) begin
      clk_d = 1'b0;
      act_d = 1'b0;
    end else if (act_q) begin
      cnt_d = cnt_inc[W-1:0];
      clk_d = (cnt_inc < high_len);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= W'(DEFAULT_DIV - 1);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      act_q  <= act_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign active  = act_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - directed and randomized checks of clock_divider_prog against a period-level model
module tb_clock_divider_prog;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       div_wr = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       sync   = 1'b0;
  logic       clk_out, tick, active, div_pend;
  logic [7:0] div_cur;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference state: position in period, divisor, pending request, run flag.
  int m_cnt = 19, m_p = 20, m_pv = 20;
  bit m_pend = 0, m_act = 0, m_tick = 0, m_clk = 0;

  int hi, tk, prev;

  clock_divider_prog #(.W(8), .DEFAULT_DIV(20)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .sync     (sync),
    .clk_out  (clk_out),
    .tick     (tick),
    .active   (active),
    .div_pend (div_pend),
    .div_cur  (div_cur)
  );

  always #5 clk_in = ~clk_in;

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 19; m_p = 20; m_pv = 20;
    m_pend = 0; m_act = 0; m_tick = 0; m_clk = 0;
  endtask

  task automatic model_step();
    bit boundary;
    if (!rst_n) return;
    boundary = m_act && (m_cnt == m_p - 1);
    m_tick = 0;
    if (en && (sync || !m_act || boundary)) begin
      if (div_wr) m_p = clampv(int'(div_in));
      else if (m_pend) m_p = m_pv;
      m_pend = 0;
      m_cnt  = 0;
      m_act  = 1;
      m_tick = 1;
    end else begin
      if (div_wr) begin
        m_pv   = clampv(int'(div_in));
        m_pend = 1;
      end
      if (boundary) m_act = 0;
      else if (m_act) m_cnt++;
    end
    m_clk = m_act && (m_cnt < (m_p + 1) / 2);
  endtask

  task automatic check_all();
    chk("clk_out",  32'(clk_out),  32'(m_clk));
    chk("tick",     32'(tick),     32'(m_tick));
    chk("active",   32'(active),   32'(m_act));
    chk("div_pend", 32'(div_pend), 32'(m_pend));
    chk("div_cur",  32'(div_cur),  32'(m_p));
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    check_all();
    div_wr = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic wait_cnt(input int p, input int c);
    for (int k = 0; k < 300 && !(m_p == p && m_cnt == c && m_act); k++) cyc();
  endtask

  initial begin
    // Reset state
    en = 1'b1;
    repeat (2) @(negedge clk_in);
    check_all();
    chk("rst_div_cur", 32'(div_cur), 32'd20);

    // Start straight out of reset, default divisor 20
    rst_n = 1'b1;
    hi = 0; tk = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      hi += int'(clk_out);
      tk += int'(tick);
    end
    chk("p20_high_cycles", 32'(hi), 32'd10);
    chk("p20_ticks", 32'(tk), 32'd1);
    repeat (5) cyc();

    // Write 5 mid-period; applied at the 20-cycle boundary
    wait_cnt(20, 3);
    div_wr = 1'b1; div_in = 8'd5;
    cyc();
    chk("p5_pending", 32'(div_pend), 32'd1);
    wait_cnt(5, 0);
    chk("p5_applied", 32'(div_cur), 32'd5);
    hi = 0; tk = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      hi += int'(clk_out);
      tk += int'(tick);
    end
    chk("p5_high_cycles", 32'(hi), 32'd9);
    chk("p5_ticks", 32'(tk), 32'd3);

    // Last write wins: 1 then 7
    div_wr = 1'b1; div_in = 8'd1;
    cyc();
    div_wr = 1'b1; div_in = 8'd7;
    cyc();
    wait_cnt(7, 1);
    chk("last_wins", 32'(div_cur), 32'd7);
    div_wr = 1'b1; div_in = 8'd0;
    cyc();
    wait_cnt(2, 1);
    chk("clamp0", 32'(div_cur), 32'd2);
    prev = int'(clk_out);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("p2_toggle", 32'(clk_out), 32'(prev == 0));
      prev = int'(clk_out);
    end

    // Stop at period end, divisor 20
    div_wr = 1'b1; div_in = 8'd20;
    cyc();
    wait_cnt(20, 4);
    en = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    chk("stopped_active", 32'(active), 32'd0);
    chk("stopped_clk", 32'(clk_out), 32'd0);
    en = 1'b1;
    cyc();
    chk("restart_tick", 32'(tick), 32'd1);

    // Sync with simultaneous write of 6
    wait_cnt(20, 7);
    sync = 1'b1; div_wr = 1'b1; div_in = 8'd6;
    cyc();
    chk("sync_tick", 32'(tick), 32'd1);
    chk("sync_div", 32'(div_cur), 32'd6);
    repeat (12) cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      en     = ($urandom % 8) != 0;
      div_wr = ($urandom % 10) == 0;
      div_in = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % 12);
      sync   = ($urandom % 25) == 0;
      cyc();
    end

    // Async reset while high with a pending write
    en = 1'b1;
    div_wr = 1'b1; div_in = 8'd6;
    cyc();
    for (int k = 0; k < 300 && !(m_p == 6 && m_cnt == 0); k++) cyc();
    div_wr = 1'b1; div_in = 8'd9;
    cyc();
    chk("pre_rst_clk", 32'(clk_out), 32'd1);
    chk("pre_rst_pend", 32'(div_pend), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_clk", 32'(clk_out), 32'd0);
    chk("async_div", 32'(div_cur), 32'd20);
    chk("async_pend", 32'(div_pend), 32'd0);
    chk("async_active", 32'(active), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (25) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable integer clock divider; successor to the fixed-divisor divider used in the testbench clocking tree. It generates a registered divided clock plus a single-cycle tick strobe from clk_in. Features:
- Parametrised counter width.
- Odd divisors with high phase = ceil(P/2).
- Glitch-free divisor change applied only at a period boundary.
- Clean start/stop gating.
- Synchronous phase-restart input for aligning multiple dividers.

Parameters:
W, 8, width of divisor and internal counter (divisors 2..2^W-1)
DEFAULT_DIV, 20, divisor loaded at reset; must be >=2 and <2^W

Ports:
clk_in  in  1  source clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  run request; stop takes effect at period end
div_wr  in  1  one-cycle strobe: capture div_in into pending register
div_in  in  W  requested divisor
sync  in  1  synchronous phase restart; honoured only when en=1
clk_out  out  1  divided clock, registered
tick  out  1  high for exactly the first clk_in cycle of each divided period
active  out  1  divider running
div_pend  out  1  written divisor not yet applied
div_cur  out  W  divisor governing the current period (after clamping)

Behaviour:
- Effective divisor P = div_cur. H = (P+1)>>1.
- Written values 0 or 1 are clamped to 2 at capture.
- Internal counter cnt runs 0..P-1.
- Invariant whenever active=1: clk_out == (cnt < H) and tick == (cnt == 0). All outputs are registers.
- Reset (async, rst_n=0):
  - cnt = P-1, div_cur = DEFAULT_DIV.
  - clk_out = 0, tick = 0, active = 0, div_pend = 0.
- Start: at a posedge with en=1 and active=0:
  - cnt->0, clk_out->1, tick->1, active->1.
  - Latency from reset release with en=1 held: first posedge.
- Period boundary: posedge with cnt==P-1 and active=1.
  - If en=1: cnt->0; if div_pend, div_cur<-pending and div_pend->0, and the new period uses the new P and H.
  - If en=0: stop. cnt holds P-1, clk_out->0, tick->0, active->0.
  - A pending divisor is applied at the next start.
  - en deasserted mid-period never truncates a high or low phase.
- div_wr:
  - Pending register <- clamp(div_in); div_pend->1 on the next edge.
  - A second write while pending overwrites the pending value (last wins).
  - div_wr coinciding with a boundary: the just-written value is applied at that boundary and div_pend stays 0.
- sync (en=1):
  - Next posedge forces cnt->0, clk_out->1, tick->1, active->1, regardless of cnt.
  - Any pending divisor is applied immediately.
  - sync together with div_wr: div_in (clamped) is applied immediately.
  - sync with en=0: ignored.
- Stopped state: cnt holds P-1, clk_out=0, tick=0; div_wr is still accepted.
- Arithmetic: cnt is W bits; the compare against P-1 prevents wrap-around. The H computation uses W+1 bits.

Decomposition:
- Shared package clkdiv_pkg holds:
  - constant CLKDIV_MIN_DIV = 2
  - function clkdiv_clamp(W-bit value)
  - default W/DEFAULT_DIV constants used by the testbench clock tree
- One natural sub-module: clkdiv_cfg_reg, holding the pending register, div_pend, div_cur, and the apply-at-boundary/sync logic.
- The counter and output logic stay in the top.

Test Plan:
- Reset released, en=1, default 20 -> first posedge tick=1, clk_out high 10 cycles then low 10; tick every 20 cycles; active=1.
- div_wr with div_in=5 at cnt=3 -> div_pend=1 until the 20-cycle period ends; then div_cur=5, clk_out high 3 / low 2, tick every 5; div_pend=0.
- div_wr with div_in=1, then div_wr with div_in=7 before the boundary -> div_cur becomes 7, not 2; a later div_in=0 -> div_cur=2, clk_out toggles every cycle.
- P=20, en dropped at cnt=4 -> high phase completes (cnt 0..9), low to cnt 19, then active=0 and clk_out=0 held; en raised -> next posedge tick=1, clk_out=1.
- P=20, sync with div_wr(div_in=6) at cnt=7 -> next posedge cnt=0, tick=1, div_cur=6, high 3 / low 3 thereafter.
- rst_n pulled low while clk_out=1 with div_pend=1 -> clk_out=0 immediately (no clock edge needed); div_cur=20, div_pend=0, active=0.
